// File: rtl/timed_ram.sv
// timed_ram: word-addressed 32-bit memory with a fixed, programmable access
// latency. It serves a level-sensitive requester. A request is any change
// of the held {data, addr, wr} bundle. While an access is pending, `state`
// is low. When the access completes, `state` returns high and `ack` pulses
// for one cycle.
module timed_ram #(
  parameter int unsigned AW      = 8,  // word-index width, 2^AW words
  parameter int unsigned LATENCY = 4   // request-to-completion cycles, 1..15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] data,
  input  logic [31:0] addr,
  input  logic        wr,
  output logic        state,
  output logic [31:0] q,
  output logic        ack
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } fsm_t;

  // The counter is loaded with LATENCY-1. The remaining decrements, plus
  // the completing cycle, make up the full latency.
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  fsm_t        fsm_q, fsm_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] data_r;
  logic [31:0] addr_r;
  logic        wr_r;
  logic        first;
  logic        changed;
  logic        latch_req;
  logic        complete;
  logic        mem_we;

  // Contents start at zero for simulation. Reset never touches the array.
  logic [31:0] mem [0:(1 << AW) - 1] = '{default: '0};

  // Any difference between the live bundle and the latched copy is a new request.
  // The full 32-bit address is compared. Aliased upper bits still count as a change.
  assign changed = (data != data_r) || (addr != addr_r) || (wr != wr_r);

  // Next-state logic: decides launch, restart, countdown or completion.
  always_comb begin
    // NOTE: every variable gets a default before the case, so no path leaves
    // it unassigned and no latch is inferred.
    fsm_d     = fsm_q;
    cnt_d     = cnt_q;
    latch_req = 1'b0;
    complete  = 1'b0;
    case (fsm_q)
      IDLE: begin
        // `first` forces the bundle present right after reset to launch.
        // Without it, a read of address 0 would look unchanged and be lost.
        if (changed || first) begin
          latch_req = 1'b1;
          cnt_d     = CNT_LOAD;
          fsm_d     = BUSY;
        end
      end
      BUSY: begin
        if (changed) begin
          // A changed bundle aborts the pending access, even on the cycle it
          // would have completed.
          latch_req = 1'b1;
          cnt_d     = CNT_LOAD;
        end else if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          complete = 1'b1;
          fsm_d    = IDLE;
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  // A reset edge must abort a pending write, so the write enable is gated by rst_n.
  assign mem_we = complete && wr_r && rst_n;

  // Control state, request copy and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments throughout.
      // Every register then samples its pre-edge value.
      fsm_q  <= IDLE;
      cnt_q  <= 4'd0;
      data_r <= 32'd0;
      addr_r <= 32'd0;
      wr_r   <= 1'b0;
      first  <= 1'b1;
      q      <= 32'd0;
      ack    <= 1'b0;
    end else begin
      fsm_q <= fsm_d;
      cnt_q <= cnt_d;
      first <= 1'b0;
      ack   <= complete;
      if (latch_req) begin
        data_r <= data;
        addr_r <= addr;
        wr_r   <= wr;
      end
      if (complete && !wr_r) begin
        q <= mem[addr_r[AW-1:0]];
      end
    end
  end

  // Storage array: write port only.
  always_ff @(posedge clk) begin
    // NOTE: the array is deliberately not reset. This keeps it mappable to
    // RAM, and its contents must survive rst_n anyway.
    if (mem_we) begin
      mem[addr_r[AW-1:0]] <= data_r;
    end
  end

  // `state` is decoded from the FSM register alone.
  // There is no combinational path from the inputs to it.
  assign state = (fsm_q == IDLE);

endmodule

// File: tb/tb_timed_ram.sv
// Bench for timed_ram. Requests are pushed to a scoreboard when driven.
// They are popped at each completion. A small memory model supplies the
// expected q.
module tb_timed_ram;

  localparam int unsigned AW  = 8;
  localparam int unsigned LAT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] data;
  logic [31:0] addr;
  logic        wr;
  logic        state;
  logic [31:0] q;
  logic        ack;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
  } req_t;

  req_t        sb[$];
  logic [31:0] model_mem [0:(1 << AW) - 1];
  logic [31:0] model_q;
  int          checks    = 0;
  int          errors    = 0;
  int          ack_seen  = 0;
  int          exp_acks  = 0;

  timed_ram #(.AW(AW), .LATENCY(LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .data  (data),
    .addr  (addr),
    .wr    (wr),
    .state (state),
    .q     (q),
    .ack   (ack)
  );

  always #5 clk = ~clk;

  // Count every ack pulse, sampled mid-cycle.
  always @(negedge clk) begin
    if (ack === 1'b1) ack_seen++;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d);
    req_t r;
    wr   = w;
    addr = a;
    data = d;
    r.wr = w; r.addr = a; r.data = d;
    sb.push_back(r);
  endtask

  // Replace the pending (not yet completed) request with a new bundle.
  task automatic retarget(input logic w, input logic [31:0] a, input logic [31:0] d);
    if (sb.size() > 0) sb.delete(sb.size() - 1);
    issue(w, a, d);
  endtask

  // The edge that detects the request: state must drop.
  task automatic detect(input string name);
    tick();
    checks++;
    if (state !== 1'b0) begin
      errors++;
      $display("FAIL %s_detect: state=%b required 0", name, state);
    end
  endtask

  // Wait for completion. Then check latency, the ack pulse and the scoreboard q.
  task automatic wait_rest(input string name);
    int   n;
    req_t r;
    n = 0;
    do begin
      tick();
      n++;
    end while (state !== 1'b1 && n < 40);
    checks++;
    if (n != LAT) begin
      errors++;
      $display("FAIL %s_latency: cycles=%0d required %0d", name, n, LAT);
    end
    checks++;
    if (ack !== 1'b1) begin
      errors++;
      $display("FAIL %s_ack: ack=%b required 1", name, ack);
    end
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s_scoreboard: queue empty at completion, required one entry", name);
    end else begin
      r = sb.pop_front();
      exp_acks++;
      if (r.wr) model_mem[r.addr[AW-1:0]] = r.data;
      else      model_q = model_mem[r.addr[AW-1:0]];
      checks++;
      if (q !== model_q) begin
        errors++;
        $display("FAIL %s_q: q=%h required %h", name, q, model_q);
      end
    end
    tick();
    checks++;
    if (ack !== 1'b0 || state !== 1'b1) begin
      errors++;
      $display("FAIL %s_ack_drop: ack=%b state=%b required ack=0 state=1", name, ack, state);
    end
  endtask

  task automatic wait_done(input string name);
    detect(name);
    wait_rest(name);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    wr    = 1'b0;
    addr  = 32'd0;
    data  = 32'd0;
    tick();
    tick();
    checks++;
    if (state !== 1'b1 || q !== 32'd0 || ack !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: state=%b q=%h ack=%b required 1/0/0", state, q, ack);
    end
    rst_n = 1'b1;
    issue(1'b0, 32'd0, 32'd0);
    wait_done("reset_first");
  endtask

  task automatic test_write_read();
    issue(1'b1, 32'h05, 32'hDEADBEEF);
    wait_done("wr_write");
    issue(1'b0, 32'h05, 32'hDEADBEEF);
    wait_done("wr_read");
  endtask

  task automatic test_alias();
    issue(1'b1, 32'h105, 32'h12345678);
    wait_done("alias_write");
    issue(1'b0, 32'h05, 32'h12345678);
    wait_done("alias_read");
  endtask

  task automatic test_abort();
    int acks_before;
    acks_before = ack_seen;
    issue(1'b1, 32'h07, 32'hAAAA0000);
    detect("abort_start");
    tick();
    tick();
    checks++;
    if (state !== 1'b0 || ack_seen != acks_before) begin
      errors++;
      $display("FAIL abort_midway: state=%b acks=%0d required state=0 acks=%0d",
               state, ack_seen, acks_before);
    end
    retarget(1'b1, 32'h08, 32'hAAAA0000);
    wait_done("abort_restart");
    issue(1'b0, 32'h07, 32'hAAAA0000);
    wait_done("abort_read7");
    issue(1'b0, 32'h08, 32'hAAAA0000);
    wait_done("abort_read8");
  endtask

  task automatic test_collision();
    logic [31:0] q_before;
    q_before = model_q;
    issue(1'b0, 32'h05, 32'h0);
    detect("coll_start");
    repeat (LAT - 1) tick();
    retarget(1'b0, 32'h07, 32'h0);
    detect("coll_restart");
    checks++;
    if (ack !== 1'b0 || q !== q_before) begin
      errors++;
      $display("FAIL coll_edge: ack=%b q=%h required ack=0 q=%h", ack, q, q_before);
    end
    wait_rest("coll_restart");
  endtask

  task automatic test_back_to_back();
    int acks_before;
    issue(1'b1, 32'h0F, 32'hC0FFEE01);
    wait_done("b2b_write");
    issue(1'b0, 32'h0F, 32'hC0FFEE01);
    wait_done("b2b_read");
    acks_before = ack_seen;
    repeat (6) tick();
    checks++;
    if (state !== 1'b1 || ack_seen != acks_before) begin
      errors++;
      $display("FAIL held_bundle: state=%b acks=%0d required state=1 acks=%0d",
               state, ack_seen, acks_before);
    end
  endtask

  task automatic test_reset_busy();
    int acks_before;
    acks_before = ack_seen;
    issue(1'b1, 32'h03, 32'h55);
    detect("rstbusy_start");
    tick();
    tick();
    rst_n = 1'b0;
    sb.delete(sb.size() - 1);
    model_q = 32'd0;
    tick();
    checks++;
    if (state !== 1'b1 || ack !== 1'b0 || q !== 32'd0) begin
      errors++;
      $display("FAIL rstbusy_reset: state=%b ack=%b q=%h required 1/0/0", state, ack, q);
    end
    tick();
    checks++;
    if (ack_seen != acks_before) begin
      errors++;
      $display("FAIL rstbusy_noack: acks=%0d required %0d", ack_seen, acks_before);
    end
    rst_n = 1'b1;
    issue(1'b0, 32'h03, 32'h55);
    wait_done("rstbusy_read");
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) model_mem[i] = 32'd0;
    model_q = 32'd0;
    test_reset();
    test_write_read();
    test_alias();
    test_abort();
    test_collision();
    test_back_to_back();
    test_reset_busy();
    repeat (3) tick();
    checks++;
    if (ack_seen != exp_acks) begin
      errors++;
      $display("FAIL ack_total: acks=%0d required %0d", ack_seen, exp_acks);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
